wb_burst_mem_slave: RTL and testbench
=====================================

WB_BURST_MEM_SLAVE -- requirements
Module: wb_burst_mem_slave

Interface
REQ-001 SHALL have parameters: DW=32 (data width); AW=32 (address width); MEM_AW=10 (word-address bits, 1024 words); WAIT_STATES=2 (first-beat latency, 0..15); LINE_WORDS=8 (burst wrap length, 4 or 8).
REQ-002 SHALL have one clock and one reset: wb_clk_i in 1, the only clock; wb_rst_i in 1, synchronous, active-low.
REQ-003 SHALL have these ports: wb_cyc_i in 1 cycle valid; wb_stb_i in 1 strobe; wb_we_i in 1 write; wb_adr_i in AW byte address; wb_sel_i in 4 byte selects; wb_dat_i in DW write data; wb_cti_i in 3 cycle type; wb_bte_i in 2 burst type (ignored, linear assumed).
REQ-004 SHALL have these ports: wb_dat_o out DW read data; wb_ack_o out 1 normal termination; wb_err_o out 1 error termination; wb_rty_o out 1 retry, tied 0; busy_o out 1 high whenever the FSM is not IDLE.

Function
REQ-005 SHALL implement FSM states IDLE, WAIT, BURST.
REQ-006 IDLE: on wb_cyc_i&wb_stb_i, SHALL latch adr, we, sel, load wait counter with WAIT_STATES, and go to WAIT.
REQ-007 WAIT: counter decrements each cycle; at 0, SHALL register wb_ack_o=1 and go to BURST, so the first ack is high exactly WAIT_STATES+1 cycles after the request cycle.
REQ-008 Beat address SHALL be internal: beat n = {base[AW-1:5], (base[4:2]+n) mod 8} for LINE_WORDS=8, or {base[AW-1:4], (base[3:2]+n) mod 4} for 4; wb_adr_i is ignored after latch.
REQ-009 Read: wb_dat_o SHALL hold mem[beat address] in every cycle wb_ack_o=1; the next word is prefetched one cycle ahead so consecutive beats need no bubbles.
REQ-010 Write: at each edge with wb_ack_o&wb_stb_i&wb_we_i, SHALL update the bytes of mem[beat address] enabled by wb_sel_i from wb_dat_i; lanes with sel=0 are unchanged.
REQ-011 BURST, cti_i=010 at an acked edge: SHALL advance the beat address and keep wb_ack_o=1 on the next cycle (one beat per clock).
REQ-012 BURST, cti_i=111 or 000 at an acked edge: SHALL complete that beat, return to IDLE, and drive wb_ack_o=0 on the next cycle; a new request needs a fresh IDLE sample, so there is at least one idle cycle between cycles.
REQ-013 BURST, wb_cyc_i=1 and wb_stb_i=0: SHALL drive wb_ack_o=0 next cycle, hold the beat address, and resume acking the cycle after stb returns.
REQ-014 wb_cyc_i=0 in WAIT or BURST, including the cycle ack is high: SHALL abort to IDLE with ack/err 0 next cycle; unacked writes are not performed.
REQ-015 wb_ack_o and wb_err_o SHALL never be high in the same cycle.
REQ-016 Beat address word index >= 2^MEM_AW SHALL be out of range (see REQ-021/022).

Reset
REQ-017 On wb_rst_i=0 at a clock edge, SHALL set state=IDLE, wb_ack_o=0, wb_err_o=0, wb_rty_o=0, busy_o=0, wb_dat_o=0, and clear the wait counter and beat index.
REQ-018 Reset mid-burst SHALL drop the transfer the next cycle with no further acks; memory contents are not reset.
REQ-019 Outputs SHALL be 0 while reset is held, regardless of wb_cyc_i/wb_stb_i.

Configuration
REQ-020 The feature SHALL be controlled by the macro WB_SLAVE_ERR_EN.
REQ-021 With WB_SLAVE_ERR_EN defined: an out-of-range beat SHALL assert wb_err_o, not wb_ack_o, in its termination cycle, return to IDLE whatever cti_i is, and not write memory.
REQ-022 With WB_SLAVE_ERR_EN undefined: wb_err_o SHALL be tied 0; out-of-range reads ack with data 0; out-of-range writes ack and are discarded.

Verification
REQ-023 Reset: hold wb_rst_i=0 three cycles with cyc=stb=1 -> ack=err=busy=0, dat_o=0.
REQ-024 Read burst: mem[0x40>>2..+7]=0x11..0x88, WAIT_STATES=2, read adr=0x40, cti=010 x7 then 111 -> first ack 3 cycles after request, 8 consecutive acks with data 0x11..0x88, ack=0 after last.
REQ-025 Wrap: read adr=0x58, cti 010/111, LINE_WORDS=8 -> beats at words 0x58,0x5C,0x40,...,0x54 (byte addresses); 8 acks.
REQ-026 Classic write: adr=0x10, sel=4'b0011, dat=0xAABBCCDD over mem 0x12345678, cti=000 -> one ack, mem=0x1234CCDD, ack low next cycle.
REQ-027 Stb gap: drop stb for 2 cycles after beat 3 of an 8-beat read -> ack low for those cycles, beats 4..7 resume with correct data; total acks=8.
REQ-028 Out of range: adr=4<<MEM_AW read -> ERR_EN defined: one err pulse, no ack, IDLE; undefined: one ack with dat_o=0.

Source files
------------

// File: rtl/wb_burst_mem_slave.sv
`default_nettype none
// ============================================================================
// Module : wb_burst_mem_slave
// Desc   : Wishbone burst memory slave with wrapped line bursts and a fixed
//          first-beat latency. Define WB_SLAVE_ERR_EN for error termination.
// Rev    : 1.0  initial release
// ============================================================================
module wb_burst_mem_slave #(
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter int MEM_AW      = 10,
    parameter int WAIT_STATES = 2,
    parameter int LINE_WORDS  = 8
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic          wb_we_i,
    input  logic [AW-1:0] wb_adr_i,
    input  logic [3:0]    wb_sel_i,
    input  logic [DW-1:0] wb_dat_i,
    input  logic [2:0]    wb_cti_i,
    input  logic [1:0]    wb_bte_i,
    output logic [DW-1:0] wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic          wb_rty_o,
    output logic          busy_o
);

    localparam int              c_LB       = (LINE_WORDS == 4) ? 2 : 3;
    localparam int              c_WW       = AW - 2;
    localparam int              c_LANE_W   = DW / 4;
    localparam logic [2:0]      c_CTI_INCR = 3'b010;
    localparam logic [c_LB-1:0] c_IDX_ONE  = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_BURST = 2'd2
    } state_t;

    state_t              r_state;
    logic [DW-1:0]       r_mem [0:(2**MEM_AW)-1];
    logic [c_WW-1:0]     r_base;
    logic                r_we;
    logic [3:0]          r_sel;
    logic [3:0]          r_cnt;
    logic [c_LB-1:0]     r_idx;
    logic                r_ack;
    logic                r_err;
    logic [DW-1:0]       r_dat;

    logic [c_WW-1:0]     w_req_word;
    logic [c_WW-1:0]     w_cur_word;
    logic [c_WW-1:0]     w_nxt_word;
    logic [c_WW-1:0]     w_iss_word;
    logic                w_cur_oor;
    logic                w_iss_oor;
    logic [DW-1:0]       w_iss_dat;
    logic                w_iss_ack;
    logic                w_iss_err;
    logic                w_wr;
    logic                w_unused;

    // Only the low line-index bits move; the carry out is discarded so bursts wrap.
    function automatic logic [c_WW-1:0] f_beat_word(input logic [c_WW-1:0] base,
                                                    input logic [c_LB-1:0] idx);
        f_beat_word = {base[c_WW-1:c_LB], base[c_LB-1:0] + idx};
    endfunction

    assign w_req_word = f_beat_word(wb_adr_i[AW-1:2], '0);
    assign w_cur_word = f_beat_word(r_base, r_idx);
    assign w_nxt_word = f_beat_word(r_base, r_idx + c_IDX_ONE);
    assign w_cur_oor  = |w_cur_word[c_WW-1:MEM_AW];

    // Word whose data and termination are registered at this edge if a beat is issued.
    always_comb begin
        w_iss_word = w_cur_word;
        if (r_state == S_IDLE) begin
            w_iss_word = w_req_word;
        end else if (r_state == S_BURST && r_ack && wb_stb_i) begin
            w_iss_word = w_nxt_word;
        end
        w_iss_oor = |w_iss_word[c_WW-1:MEM_AW];
        w_iss_dat = w_iss_oor ? '0 : r_mem[w_iss_word[MEM_AW-1:0]];
`ifdef WB_SLAVE_ERR_EN
        w_iss_ack = !w_iss_oor;
        w_iss_err = w_iss_oor;
`else
        w_iss_ack = 1'b1;
        w_iss_err = 1'b0;
`endif
    end

    assign w_wr = wb_rst_i && (r_state == S_BURST) && r_ack && r_we &&
                  wb_cyc_i && wb_stb_i && wb_we_i && !w_cur_oor;

    always_ff @(posedge wb_clk_i) begin
        if (w_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (wb_sel_i[b]) begin
                    r_mem[w_cur_word[MEM_AW-1:0]][b*c_LANE_W +: c_LANE_W] <=
                        wb_dat_i[b*c_LANE_W +: c_LANE_W];
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            r_state <= S_IDLE;
            r_base  <= '0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ack <= 1'b0;
                    r_err <= 1'b0;
                    if (wb_cyc_i && wb_stb_i) begin
                        r_base <= wb_adr_i[AW-1:2];
                        r_we   <= wb_we_i;
                        r_sel  <= wb_sel_i;
                        r_idx  <= '0;
                        if (WAIT_STATES == 0) begin
                            r_state <= S_BURST;
                            r_ack   <= w_iss_ack;
                            r_err   <= w_iss_err;
                            r_dat   <= w_iss_dat;
                        end else begin
                            r_cnt   <= 4'(WAIT_STATES);
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!wb_cyc_i) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt <= 4'd1) begin
                        r_cnt   <= '0;
                        r_state <= S_BURST;
                        r_ack   <= w_iss_ack;
                        r_err   <= w_iss_err;
                        r_dat   <= w_iss_dat;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_BURST: begin
                    if (!wb_cyc_i || r_err) begin
                        r_state <= S_IDLE;
                        r_ack   <= 1'b0;
                        r_err   <= 1'b0;
                    end else if (r_ack && wb_stb_i) begin
                        if (wb_cti_i == c_CTI_INCR) begin
                            r_idx <= r_idx + c_IDX_ONE;
                            r_ack <= w_iss_ack;
                            r_err <= w_iss_err;
                            r_dat <= w_iss_dat;
                        end else begin
                            r_state <= S_IDLE;
                            r_ack   <= 1'b0;
                        end
                    end else if (r_ack) begin
                        // Presented beat not taken by the master: hold the index.
                        r_ack <= 1'b0;
                    end else if (wb_stb_i) begin
                        r_ack <= w_iss_ack;
                        r_err <= w_iss_err;
                        r_dat <= w_iss_dat;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wb_dat_o = r_dat;
    assign wb_ack_o = r_ack;
    assign wb_err_o = r_err;
    assign wb_rty_o = 1'b0;
    assign busy_o   = (r_state != S_IDLE);

    assign w_unused = &{1'b0, wb_bte_i, wb_adr_i[1:0], r_sel};

endmodule
`default_nettype wire

// File: tb/tb_wb_burst_mem_slave.sv
`default_nettype none
// ============================================================================
// Module : tb_wb_burst_mem_slave
// Desc   : Self-checking bench for wb_burst_mem_slave against a word-array model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_wb_burst_mem_slave;

    localparam int W    = 2;
    localparam int L    = 8;
    localparam int MEMW = 1024;

    logic        wb_clk_i;
    logic        wb_rst_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [31:0] wb_adr_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_i;
    logic [2:0]  wb_cti_i;
    logic [1:0]  wb_bte_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;
    logic        busy_o;

    wb_burst_mem_slave #(
        .DW(32), .AW(32), .MEM_AW(10), .WAIT_STATES(W), .LINE_WORDS(L)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_cyc_i(wb_cyc_i),
        .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i),
        .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i), .wb_cti_i(wb_cti_i),
        .wb_bte_i(wb_bte_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o), .busy_o(busy_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    logic [31:0] mdl    [0:MEMW-1];
    logic [31:0] tx_dat [0:15];
    logic [31:0] rd_q   [$];
    bit          last_err;
    int          n_vec;
    int          n_err;

    task automatic tick;
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wrapped line address of beat n, from plain modular arithmetic on word indices.
    function automatic int bw(input int base, input int n);
        int off;
        off = base % L;
        return base - off + (off + n) % L;
    endfunction

    task automatic xfer(input logic [31:0] adr, input bit we, input int nbeats,
                        input logic [3:0] sel, input int gap_after, input int gap_len,
                        input int abort_after, input bit classic);
        int  beats, cyc_n, first_term, first_ack, last_ack, gap_left, low_run;
        int  base_w, word, exp_beats;
        bit  done, got_err, exp_err;
        logic [31:0] exp_d;
        base_w = int'(adr >> 2);
`ifdef WB_SLAVE_ERR_EN
        exp_err = (base_w >= MEMW);
`else
        exp_err = 1'b0;
`endif
        rd_q.delete();
        beats = 0; cyc_n = 0; first_term = -1; first_ack = -1; last_ack = -1;
        gap_left = gap_len; low_run = 0; done = 1'b0; got_err = 1'b0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_sel_i = sel;
        wb_cti_i = classic ? 3'b000 : ((nbeats == 1) ? 3'b111 : 3'b010);
        wb_dat_i = tx_dat[0];
        while (!done && cyc_n < 200) begin
            tick;
            cyc_n++;
            if (cyc_n == 1) chk("busy_after_req", busy_o, 1);
            if (wb_ack_o || wb_err_o) chk("ack_err_excl", wb_ack_o & wb_err_o, 0);
            if (abort_after >= 0 && beats == abort_after) begin
                wb_cyc_i = 1'b0;
                wb_stb_i = 1'b0;
                done     = 1'b1;
            end else begin
                if (beats == gap_after && gap_left > 0) begin
                    wb_stb_i = 1'b0;
                    gap_left--;
                    low_run++;
                    if (low_run >= 2) chk("gap_ack_low", wb_ack_o, 0);
                end else begin
                    if (low_run > 0) chk("resume_cycle_ack_low", wb_ack_o, 0);
                    low_run  = 0;
                    wb_stb_i = 1'b1;
                end
                wb_cti_i = classic ? 3'b000 : ((beats == nbeats - 1) ? 3'b111 : 3'b010);
                wb_dat_i = tx_dat[beats % 16];
                if (wb_err_o) begin
                    if (first_term < 0) first_term = cyc_n;
                    got_err = 1'b1;
                    done    = 1'b1;
                end else if (wb_ack_o && wb_stb_i) begin
                    if (first_term < 0) first_term = cyc_n;
                    if (first_ack < 0) first_ack = cyc_n;
                    word = bw(base_w, beats);
                    if (!we) begin
                        exp_d = (word < MEMW) ? mdl[word] : 32'h0;
                        chk("rd_data", wb_dat_o, exp_d);
                        rd_q.push_back(wb_dat_o);
                    end else if (word < MEMW) begin
                        for (int b = 0; b < 4; b++)
                            if (sel[b]) mdl[word][8*b +: 8] = wb_dat_i[8*b +: 8];
                    end
                    last_ack = cyc_n;
                    beats++;
                    if (beats == nbeats) done = 1'b1;
                end
            end
        end
        chk("xfer_completed", {31'd0, done}, 1);
        tick;
        chk("ack_low_after_end", wb_ack_o, 0);
        chk("err_low_after_end", wb_err_o, 0);
        chk("idle_after_end", busy_o, 0);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        tick;
        if (first_term >= 0) chk("first_beat_latency", first_term, W + 1);
        if (abort_after < 0 && !got_err && beats == nbeats)
            chk("burst_span", last_ack - first_ack,
                nbeats - 1 + ((gap_len > 0) ? gap_len + 1 : 0));
        exp_beats = (abort_after >= 0) ? abort_after : (exp_err ? 0 : nbeats);
        chk("beats_taken", beats, exp_beats);
        chk("err_termination", {31'd0, got_err}, {31'd0, exp_err});
        last_err = got_err;
    endtask

    initial begin
        int   nb, ga, gl;
        bit   we, cl;
        logic [31:0] a;
        logic [3:0]  s;
        n_vec = 0; n_err = 0; last_err = 1'b0;
        wb_rst_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
        wb_adr_i = 32'h40; wb_sel_i = 4'hF; wb_dat_i = '0; wb_cti_i = 3'b010; wb_bte_i = 2'b00;

        // Reset held with an active request.
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("rst_ack", wb_ack_o, 0);
            chk("rst_err", wb_err_o, 0);
            chk("rst_busy", busy_o, 0);
            chk("rst_dat", wb_dat_o, 0);
            chk("rst_rty", wb_rty_o, 0);
        end
        wb_rst_i = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        tick;

        // Preload the whole memory with write bursts.
        for (int k = 0; k < MEMW / L; k++) begin
            for (int j = 0; j < 16; j++) tx_dat[j] = $urandom;
            xfer(32'(k * L * 4), 1'b1, L, 4'hF, -1, 0, -1, 1'b0);
        end
        for (int j = 0; j < 8; j++) tx_dat[j] = 32'h11 * (j + 1);
        xfer(32'h40, 1'b1, 8, 4'hF, -1, 0, -1, 1'b0);

        // Aligned read burst.
        xfer(32'h40, 1'b0, 8, 4'hF, -1, 0, -1, 1'b0);
        chk("rd40_beat0", rd_q[0], 32'h11);
        chk("rd40_beat7", rd_q[7], 32'h88);

        // Wrapping read burst.
        xfer(32'h58, 1'b0, 8, 4'hF, -1, 0, -1, 1'b0);
        chk("wrap_beat0", rd_q[0], 32'h77);
        chk("wrap_beat1", rd_q[1], 32'h88);
        chk("wrap_beat2", rd_q[2], 32'h11);
        chk("wrap_beat7", rd_q[7], 32'h66);

        // Classic partial write, then read back.
        tx_dat[0] = 32'h12345678;
        xfer(32'h10, 1'b1, 1, 4'hF, -1, 0, -1, 1'b1);
        tx_dat[0] = 32'hAABBCCDD;
        xfer(32'h10, 1'b1, 1, 4'b0011, -1, 0, -1, 1'b1);
        xfer(32'h10, 1'b0, 1, 4'hF, -1, 0, -1, 1'b1);
        chk("classic_partial_wr", rd_q[0], 32'h1234CCDD);

        // Strobe gap of two cycles after beat 3.
        xfer(32'h40, 1'b0, 8, 4'hF, 4, 2, -1, 1'b0);
        chk("gap_beat4", rd_q[4], 32'h55);

        // Out-of-range access.
        xfer(32'd4 << 10, 1'b0, 1, 4'hF, -1, 0, -1, 1'b1);
`ifdef WB_SLAVE_ERR_EN
        chk("oor_err", {31'd0, last_err}, 1);
`else
        chk("oor_ack_data", rd_q[0], 32'h0);
`endif

        // Aborts: after two acked write beats, and during the wait phase.
        for (int j = 0; j < 16; j++) tx_dat[j] = $urandom;
        xfer(32'h80, 1'b1, 8, 4'hF, -1, 0, 2, 1'b0);
        xfer(32'h80, 1'b0, 8, 4'hF, -1, 0, -1, 1'b0);
        xfer(32'hA0, 1'b1, 4, 4'hF, -1, 0, 0, 1'b0);
        xfer(32'hA0, 1'b0, 8, 4'hF, -1, 0, -1, 1'b0);

        // Randomized transactions.
        for (int t = 0; t < 40; t++) begin
            nb = $urandom_range(1, 12);
            we = 1'($urandom_range(0, 1));
            cl = (nb == 1) && ($urandom_range(0, 1) == 1);
            a  = 32'($urandom_range(0, MEMW - 1)) << 2;
            s  = we ? 4'($urandom_range(0, 15)) : 4'hF;
            ga = (nb >= 2 && $urandom_range(0, 1) == 1) ? $urandom_range(1, nb - 1) : -1;
            gl = (ga > 0) ? $urandom_range(1, 3) : 0;
            for (int j = 0; j < 16; j++) tx_dat[j] = $urandom;
            xfer(a, we, nb, s, ga, gl, -1, cl);
        end

        // Reset in the middle of a read burst.
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h40; wb_cti_i = 3'b010;
        repeat (W + 2) tick;
        chk("rst_mid_pre_ack", wb_ack_o, 1);
        wb_rst_i = 1'b0;
        tick;
        chk("rst_mid_ack", wb_ack_o, 0);
        chk("rst_mid_busy", busy_o, 0);
        chk("rst_mid_dat", wb_dat_o, 0);
        wb_rst_i = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("rst_mid_no_ack", wb_ack_o, 0);
        end
        xfer(32'h40, 1'b0, 8, 4'hF, -1, 0, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
